// File: rtl/legv8_pkg.sv
// Shared LEGv8 instruction-field constants and opcode patterns for the IF stage and controlunit.
// Field positions follow the A64-style encoding used by the B, CBZ and B.cond formats.
package legv8_pkg;

   localparam int INSTR_W   = 32;
   localparam int OPC_W     = 11;

   localparam int OPC_MSB   = 31;
   localparam int OPC_LSB   = 21;
   localparam int IMM26_MSB = 25;
   localparam int IMM19_MSB = 23;
   localparam int IMM19_LSB = 5;

   localparam logic [INSTR_W-1:0] BUBBLE = 32'h0000_0000;

   // Opcode prefixes matched against the top bits of the 11-bit opcode field.
   localparam logic [5:0] OPC_B_PAT     = 6'b000101;
   localparam logic [5:0] OPC_BL_PAT    = 6'b100101;
   localparam logic [7:0] OPC_CBZ_PAT   = 8'b10110100;
   localparam logic [7:0] OPC_CBNZ_PAT  = 8'b10110101;
   localparam logic [7:0] OPC_BCOND_PAT = 8'b01010100;

endpackage

// File: rtl/branch_target.sv
// Branch target adder: tgt = pc + (sext(imm) << 2), imm26 for B, imm19 for CBZ/B.cond.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Wrap-around modulo 2^ADDR_W is intended behaviour.
module branch_target
   import legv8_pkg::*;
#(
   parameter int ADDR_W = 64
) (
   input  logic [ADDR_W-1:0]    pc,
   input  logic [IMM26_MSB:0]   instr,
   input  logic                 uncond,
   output logic [ADDR_W-1:0]    tgt
);

   logic [ADDR_W-1:0] off;

   always_comb begin
      off = '0;
      if (uncond) begin
         off = {{(ADDR_W-IMM26_MSB-1){instr[IMM26_MSB]}}, instr[IMM26_MSB:0]};
      end else begin
         off = {{(ADDR_W-(IMM19_MSB-IMM19_LSB+1)){instr[IMM19_MSB]}},
                instr[IMM19_MSB:IMM19_LSB]};
      end
      tgt = pc + (off << 2);
   end

endmodule

// File: rtl/instr_fetch.sv
// IF stage plus IF/ID register: PC, combinational imem address, registered word and PC.
// Latency: word fetched at pc appears on id_instr/id_pc one edge later.
// Backpressure: stall holds PC and IF/ID; a taken branch in ID overrides stall and flushes.
module instr_fetch
   import legv8_pkg::*;
#(
   parameter int                ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic [ADDR_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0]   imem_rdata,
   input  logic                 stall,
   input  logic                 br_take,
   input  logic                 br_uncond,
   output logic                 id_valid,
   output logic [INSTR_W-1:0]   id_instr,
   output logic [ADDR_W-1:0]    id_pc,
   output logic [OPC_W-1:0]     id_opcode
);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] tgt;
   logic              eff_take;

   branch_target #(.ADDR_W(ADDR_W)) u_branch_target (
      .pc     (id_pc),
      .instr  (id_instr[IMM26_MSB:0]),
      .uncond (br_uncond),
      .tgt    (tgt)
   );

   // A branch request against a bubble has no real instruction behind it.
   assign eff_take  = br_take & id_valid;
   assign imem_addr = pc;
   assign id_opcode = id_instr[OPC_MSB:OPC_LSB];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc       <= RESET_PC;
         id_valid <= 1'b0;
         id_instr <= BUBBLE;
         id_pc    <= '0;
      end else if (eff_take) begin
         pc       <= tgt;
         id_valid <= 1'b0;
         id_instr <= BUBBLE;
         id_pc    <= '0;
      end else if (!stall) begin
         pc       <= pc + ADDR_W'(4);
         id_valid <= 1'b1;
         id_instr <= imem_rdata;
         id_pc    <= pc;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed scenarios plus randomized stall/branch traffic against a reference model.
module tb_instr_fetch;
   import legv8_pkg::*;

   localparam int ADDR_W = 64;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              stall = 1'b0;
   logic              br_take = 1'b0;
   logic              br_uncond = 1'b0;
   logic              id_valid;
   logic [31:0]       id_instr;
   logic [ADDR_W-1:0] id_pc;
   logic [10:0]       id_opcode;

   logic [31:0] mem [0:255];

   int checks = 0;
   int failures = 0;

   // Reference state: next fetch address and the instruction held for decode.
   logic [63:0] m_pc;
   logic [63:0] m_idpc;
   logic [31:0] m_instr;
   logic        m_valid;

   always #5 clk = ~clk;

   assign imem_rdata = mem[imem_addr[9:2]];

   instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(64'h0)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .stall      (stall),
      .br_take    (br_take),
      .br_uncond  (br_uncond),
      .id_valid   (id_valid),
      .id_instr   (id_instr),
      .id_pc      (id_pc),
      .id_opcode  (id_opcode)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Signed word offset computed with integer arithmetic, then scaled to bytes.
   function automatic logic [63:0] ref_target(input logic [63:0] pc, input logic [31:0] w,
                                              input logic unc);
      longint off;
      if (unc) begin
         off = longint'(w & 32'h03FF_FFFF);
         if (off >= 64'sh0200_0000) off = off - 64'sh0400_0000;
      end else begin
         off = longint'((w >> 5) & 32'h0007_FFFF);
         if (off >= 64'sh0004_0000) off = off - 64'sh0008_0000;
      end
      return pc + 64'(off * 4);
   endfunction

   task automatic model_reset();
      m_pc    = 64'h0;
      m_idpc  = 64'h0;
      m_instr = 32'h0;
      m_valid = 1'b0;
   endtask

   task automatic model_edge(input logic s, input logic t, input logic u);
      logic [63:0] nt;
      if (t && m_valid) begin
         nt      = ref_target(m_idpc, m_instr, u);
         m_pc    = nt;
         m_valid = 1'b0;
         m_instr = 32'h0;
         m_idpc  = 64'h0;
      end else if (!s) begin
         m_valid = 1'b1;
         m_instr = mem[m_pc[9:2]];
         m_idpc  = m_pc;
         m_pc    = m_pc + 64'd4;
      end
   endtask

   task automatic compare_all(input string ph);
      check({ph, ".imem_addr"}, imem_addr, m_pc);
      check({ph, ".id_valid"}, 64'(id_valid), 64'(m_valid));
      check({ph, ".id_instr"}, 64'(id_instr), 64'(m_instr));
      check({ph, ".id_pc"}, id_pc, m_idpc);
      check({ph, ".id_opcode"}, 64'(id_opcode), 64'(m_instr >> 21));
   endtask

   task automatic cycle(input string ph, input logic s, input logic t, input logic u);
      stall     = s;
      br_take   = t;
      br_uncond = u;
      @(posedge clk);
      model_edge(s, t, u);
      #1;
      compare_all(ph);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[4]  = 32'h1400_0003;   // 0x10: B +3
      mem[7]  = 32'h1400_0009;   // 0x1C: B +9 -> 0x40
      mem[16] = 32'hB4FF_FFC0;   // 0x40: CBZ imm19=-2
      model_reset();

      // Reset held for two edges.
      @(posedge clk);
      @(posedge clk);
      #1;
      compare_all("rst_hold");
      reset = 1'b1;

      cycle("t1_e1", 1'b0, 1'b0, 1'b0);
      check("t1_addr_e1", imem_addr, 64'h4);
      check("t1_idpc_e1", id_pc, 64'h0);
      check("t1_vld_e1", 64'(id_valid), 64'h1);
      cycle("t1_e2", 1'b0, 1'b0, 1'b0);
      check("t1_addr_e2", imem_addr, 64'h8);
      check("t1_idpc_e2", id_pc, 64'h4);
      cycle("t1_e3", 1'b0, 1'b0, 1'b0);
      cycle("t1_e4", 1'b0, 1'b0, 1'b0);
      cycle("t1_e5", 1'b0, 1'b0, 1'b0);
      check("t2_idpc_b", id_pc, 64'h10);

      // B +3 at 0x10 redirects to 0x1C with a bubble.
      cycle("t2_take", 1'b0, 1'b1, 1'b1);
      check("t2_pc_tgt", imem_addr, 64'h1C);
      check("t2_bubble", 64'(id_valid), 64'h0);
      check("t2_bubble_opc", 64'(id_opcode), 64'h0);
      cycle("t2_after", 1'b0, 1'b0, 1'b0);
      check("t2_idpc_tgt", id_pc, 64'h1C);

      // Three stall cycles at pc=0x20, then stall and taken branch together.
      for (int i = 0; i < 3; i++) begin
         cycle("t4_stall", 1'b1, 1'b0, 1'b0);
         check("t4_pc_hold", imem_addr, 64'h20);
         check("t4_idpc_hold", id_pc, 64'h1C);
         check("t4_instr_hold", 64'(id_instr), 64'h1400_0009);
      end
      cycle("t4_stall_take", 1'b1, 1'b1, 1'b1);
      check("t4_redirect", imem_addr, 64'h40);
      check("t4_bubble", 64'(id_valid), 64'h0);
      cycle("t3_fetch", 1'b0, 1'b0, 1'b0);
      check("t3_idpc", id_pc, 64'h40);

      // CBZ imm19=-2 at 0x40 goes back to 0x38.
      cycle("t3_take", 1'b0, 1'b1, 1'b0);
      check("t3_pc_neg", imem_addr, 64'h38);
      check("t3_bubble", 64'(id_valid), 64'h0);

      // Branch request against a bubble is ignored.
      cycle("t5_ign", 1'b0, 1'b1, 1'b0);
      check("t5_pc_inc", imem_addr, 64'h3C);
      check("t5_idpc", id_pc, 64'h38);

      for (int i = 0; i < 64 && m_pc != 64'h80; i++) cycle("t6_run", 1'b0, 1'b0, 1'b0);
      check("t6_at_80", imem_addr, 64'h80);
      cycle("t6_stall", 1'b1, 1'b0, 1'b0);
      cycle("t6_stall", 1'b1, 1'b1, 1'b0);

      // Asynchronous reset between edges while stalled.
      #3;
      reset = 1'b0;
      model_reset();
      #1;
      compare_all("t6_async");
      check("t6_addr_clr", imem_addr, 64'h0);
      @(posedge clk);
      #1;
      compare_all("t6_held");
      stall   = 1'b0;
      br_take = 1'b0;
      reset   = 1'b1;
      cycle("t6_resume", 1'b0, 1'b0, 1'b0);
      check("t6_resume_idpc", id_pc, 64'h0);
      check("t6_resume_vld", 64'(id_valid), 64'h1);
      check("t6_resume_addr", imem_addr, 64'h4);

      // Random traffic, including wrapping branch targets.
      for (int i = 0; i < 3000; i++) begin
         cycle("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)));
      end

      stall   = 1'b0;
      br_take = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
